uart_cmd_framer: RTL
====================

Name: uart_cmd_framer

Overview:
- Packet-level controller on the receive side of the opponent serial link.
- Sequences the byte stream from uart_rx (rx_done_tick, dout) into 4-byte command frames:
  - SOF 0xA5
  - CMD
  - ARG
  - CHK = 0xA5 ^ CMD ^ ARG
- Validates frames, enforces an inter-byte timeout counted in s_tick units, and hands decoded moves to the game FSM through a one-entry valid/ready slot.

Parameters:
- TIMEOUT_TICKS, 320, s_tick count without a new byte before an in-progress frame is abandoned (2 bytes at 16x oversampling); legal range 2..1023.
- MAX_CELL, 8, highest legal board cell index for CMD_MOVE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- s_tick  in  1  oversampling tick, same source as uart_rx
- rx_done_tick  in  1  one-cycle strobe, received byte valid on rx_data
- rx_data  in  8  received byte
- cmd_valid  out  1  decoded command held in slot
- cmd_ready  in  1  consumer accepts slot when cmd_valid & cmd_ready
- cmd_code  out  2  1=MOVE, 2=NEW_GAME, 3=ACK
- cmd_cell  out  4  cell index for MOVE, 0 otherwise
- err_chk  out  1  one-cycle pulse, checksum mismatch
- err_cmd  out  1  one-cycle pulse, unknown CMD or cell > MAX_CELL
- err_timeout  out  1  one-cycle pulse, frame abandoned
- err_overrun  out  1  one-cycle pulse, good frame dropped because slot full
- err_count  out  8  saturating count of all error pulses

Behaviour:
- Reset (async): state IDLE, timeout counter 0, cmd_valid 0, cmd_code 0, cmd_cell 0, all err_* 0, err_count 0.
- States IDLE, GET_CMD, GET_ARG, GET_CHK. Transitions happen only on rx_done_tick, except timeout.
  - IDLE: byte == 0xA5 -> GET_CMD; any other byte is discarded silently (no error).
  - GET_CMD: latch CMD -> GET_ARG.
  - GET_ARG: latch ARG -> GET_CHK.
  - GET_CHK: compare and decode in the same cycle, go to IDLE; outputs update on the next edge.
- No resync on 0xA5 mid-frame: a 0xA5 received in GET_CMD/GET_ARG/GET_CHK is ordinary data.
- Decode on CHK byte, in priority order:
  1. CHK mismatch -> err_chk.
  2. CMD not in {0x01, 0x02, 0x03}, or CMD 0x01 with ARG > MAX_CELL -> err_cmd.
  3. Otherwise the frame is good. ARG is ignored for 0x02/0x03; cmd_cell is forced to 0 for those.
- Slot handling for a good frame:
  - Slot empty, or (cmd_valid & cmd_ready) in the same cycle -> load slot, cmd_valid = 1 next cycle.
  - Slot full with no accept -> frame dropped, err_overrun, slot contents unchanged.
- cmd_valid clears the cycle after cmd_valid & cmd_ready unless reloaded. cmd_code/cmd_cell are stable while cmd_valid = 1.
- Latency: cmd_valid rises 1 clk after the rx_done_tick carrying CHK.
- Timeout counter (10 bits):
  - Active only outside IDLE; cleared on entering GET_CMD and on every rx_done_tick.
  - Increments on s_tick.
  - On s_tick when count == TIMEOUT_TICKS-1 -> IDLE, err_timeout, counter 0.
  - rx_done_tick in the same cycle as expiry: the byte wins, counter clears, no timeout.
- Error pulses are exactly one clk. At most one err_* fires per cycle, in priority chk > cmd > overrun > timeout.
- err_count increments by 1 per pulse and saturates at 255.
- Reset mid-frame: partial frame discarded; the slot and err_count are also cleared.
- s_tick and rx_done_tick may coincide; both are processed as above.

Decomposition:
- Shared package uart_cmd_pkg:
  - SOF = 8'hA5
  - CMD_MOVE = 8'h01, CMD_NEW_GAME = 8'h02, CMD_ACK = 8'h03
  - 2-bit code encodings
  - state encoding localparams
- Sub-module: none required; timeout counter and slot stay inline.
- Top level instantiates uart_rx -> uart_cmd_framer -> game FSM.

Test Plan:
- Bytes A5 01 04 A0 (A5^01^04 = A0), cmd_ready = 1 -> cmd_valid pulse 1 clk after last byte, cmd_code = 1, cmd_cell = 4, no errors.
- A5 01 04 A1 -> err_chk pulse, cmd_valid stays 0, err_count = 1; follow-up A5 02 00 A7 -> cmd_code = 2, cmd_cell = 0.
- A5 01 09 AD -> err_cmd; A5 07 00 A2 -> err_cmd; err_count = 2.
- cmd_ready = 0: two good frames A5 03 00 A6 then A5 01 00 A4 -> slot holds ACK, err_overrun on the second; raise cmd_ready at the second CHK cycle -> no overrun, slot = MOVE cell 0.
- A5 01, then 320 s_ticks idle -> err_timeout on tick 320, state IDLE; repeat with a byte arriving on tick 320 -> no timeout, frame continues.
- Garbage 00 FF 13 in IDLE -> no errors. Assert reset mid-frame after A5 01 -> all outputs 0; then A5 01 04 A0 decodes correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the opponent-link command framer.
// Frame layout: SOF, CMD, ARG, CHK where CHK = SOF ^ CMD ^ ARG.
package uart_cmd_pkg;

   localparam logic [7:0] SOF          = 8'hA5;
   localparam logic [7:0] CMD_MOVE     = 8'h01;
   localparam logic [7:0] CMD_NEW_GAME = 8'h02;
   localparam logic [7:0] CMD_ACK      = 8'h03;

   localparam logic [1:0] CODE_NONE     = 2'd0;
   localparam logic [1:0] CODE_MOVE     = 2'd1;
   localparam logic [1:0] CODE_NEW_GAME = 2'd2;
   localparam logic [1:0] CODE_ACK      = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GET_CMD = 2'd1,
      ST_GET_ARG = 2'd2,
      ST_GET_CHK = 2'd3
   } framer_state_t;

   function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] arg);
      return SOF ^ cmd ^ arg;
   endfunction

endpackage

// File: rtl/uart_cmd_framer.sv
// Assembles 4-byte command frames from uart_rx, validates them and hands
// decoded moves to the game FSM through a one-entry valid/ready slot.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | hunting for SOF, other bytes dropped silently
// ST_GET_CMD | SOF seen, waiting for CMD byte
// ST_GET_ARG | CMD latched, waiting for ARG byte
// ST_GET_CHK | ARG latched, next byte is checked and decoded
module uart_cmd_framer
   import uart_cmd_pkg::*;
#(
   parameter int TIMEOUT_TICKS = 320,
   parameter int MAX_CELL      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [1:0] cmd_code,
   output logic [3:0] cmd_cell,
   output logic       err_chk,
   output logic       err_cmd,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic [7:0] err_count
);

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_TICKS - 1);
   localparam logic [7:0] CELL_MAX = 8'(MAX_CELL);

   framer_state_t state_q, state_d;
   logic [7:0]    cmd_q, arg_q;
   logic [9:0]    tmo_cnt_q;

   logic       chk_ev, cmd_ev, ovr_ev, tmo_ev, good, load, any_err;
   logic [1:0] code_d;
   logic [3:0] cell_d;

   always_comb begin
      state_d = state_q;
      chk_ev  = 1'b0;
      cmd_ev  = 1'b0;
      good    = 1'b0;
      tmo_ev  = (state_q != ST_IDLE) && s_tick && !rx_done_tick && (tmo_cnt_q == TMO_LAST);

      case (state_q)
         ST_IDLE:    if (rx_done_tick && rx_data == SOF) state_d = ST_GET_CMD;
         ST_GET_CMD: if (rx_done_tick) state_d = ST_GET_ARG;
         ST_GET_ARG: if (rx_done_tick) state_d = ST_GET_CHK;
         ST_GET_CHK: begin
            if (rx_done_tick) begin
               state_d = ST_IDLE;
               if (rx_data != frame_chk(cmd_q, arg_q))
                  chk_ev = 1'b1;
               else if (!(cmd_q inside {CMD_MOVE, CMD_NEW_GAME, CMD_ACK}) ||
                        (cmd_q == CMD_MOVE && arg_q > CELL_MAX))
                  cmd_ev = 1'b1;
               else
                  good = 1'b1;
            end
         end
         default:    state_d = ST_IDLE;
      endcase

      if (tmo_ev) state_d = ST_IDLE;

      // A good frame may replace the slot only if it is empty or being taken this cycle.
      load    = good && (!cmd_valid || cmd_ready);
      ovr_ev  = good && cmd_valid && !cmd_ready;
      any_err = chk_ev || cmd_ev || ovr_ev || tmo_ev;

      case (cmd_q)
         CMD_MOVE:     code_d = CODE_MOVE;
         CMD_NEW_GAME: code_d = CODE_NEW_GAME;
         default:      code_d = CODE_ACK;
      endcase
      cell_d = (cmd_q == CMD_MOVE) ? arg_q[3:0] : 4'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cmd_q   <= 8'd0;
         arg_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         if (rx_done_tick && state_q == ST_GET_CMD) cmd_q <= rx_data;
         if (rx_done_tick && state_q == ST_GET_ARG) arg_q <= rx_data;
      end
   end

   // A byte in the expiry cycle wins: rx_done_tick clears before s_tick is considered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tmo_cnt_q <= 10'd0;
      else if (state_q == ST_IDLE || rx_done_tick || tmo_ev)
         tmo_cnt_q <= 10'd0;
      else if (s_tick)
         tmo_cnt_q <= tmo_cnt_q + 10'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_valid <= 1'b0;
         cmd_code  <= CODE_NONE;
         cmd_cell  <= 4'd0;
      end else if (load) begin
         cmd_valid <= 1'b1;
         cmd_code  <= code_d;
         cmd_cell  <= cell_d;
      end else if (cmd_valid && cmd_ready) begin
         cmd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_chk     <= 1'b0;
         err_cmd     <= 1'b0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         err_chk     <= chk_ev;
         err_cmd     <= cmd_ev && !chk_ev;
         err_overrun <= ovr_ev && !chk_ev && !cmd_ev;
         err_timeout <= tmo_ev && !chk_ev && !cmd_ev && !ovr_ev;
         if (any_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

endmodule
